// File: rtl/riscx_pkg.sv
// Shared riscx core definitions: widths, reset PC and fetch-stage state encoding.
package riscx_pkg;

  localparam int          XLEN         = 32;
  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  // Fetch FSM: S_REQ may issue, S_WAIT has one request outstanding,
  // S_DROP owes a response that must be thrown away (redirected while waiting).
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/dff_lr.sv
// Register primitive: async active-low reset to RST_VAL, load enable.
// RST_VAL defaults to zero; a non-zero value gives the set-value variant.
module dff_lr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; reset value on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ifu_out_stage.sv
// One-entry valid/ready output register between fetch and decode.
// Flush wins over load and over the consumer handshake.
module ifu_out_stage
  import riscx_pkg::*;
#(
  parameter int XW = XLEN,
  parameter int IW = INSTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          load,
  input  logic [XW-1:0] load_pc,
  input  logic [IW-1:0] load_instr,
  input  logic          load_err,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [XW-1:0] out_pc,
  output logic [IW-1:0] out_instr,
  output logic          out_err,
  output logic          space
);

  logic valid_d;
  logic pay_en;

  // Room for a new instruction once the current one leaves (or there is none).
  assign space  = !out_valid | out_ready;
  assign pay_en = load & !flush;

  // Next valid: flush clears, load sets, handshake drains, otherwise hold.
  always_comb begin
    valid_d = out_valid;
    if (flush)                       valid_d = 1'b0;
    else if (load)                   valid_d = 1'b1;
    else if (out_valid && out_ready) valid_d = 1'b0;
  end

  dff_lr #(.W(1)) u_valid (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(valid_d), .q(out_valid)
  );

  // Payload only changes on a load, so it holds while stalled.
  dff_lr #(.W(XW)) u_pc (
    .clk(clk), .rst_n(rst_n), .en(pay_en), .d(load_pc), .q(out_pc)
  );

  dff_lr #(.W(IW)) u_instr (
    .clk(clk), .rst_n(rst_n), .en(pay_en), .d(load_instr), .q(out_instr)
  );

  dff_lr #(.W(1)) u_err (
    .clk(clk), .rst_n(rst_n), .en(pay_en), .d(load_err), .q(out_err)
  );

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in
// flight and hands fetched words to decode through ifu_out_stage.
// Redirects override everything and turn an in-flight fetch into a drop.
module ifu_fetch
  import riscx_pkg::*;
#(
  parameter int             XLEN     = riscx_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscx_pkg::RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               imem_rsp_err,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_err
);

  ifu_state_e      state;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] req_pc_r;
  logic [XLEN-1:0] redir_tgt;
  logic            space;
  logic            accept;
  logic            rsp_load;
  logic            unused_redir_lo;

  // Low address bits of a redirect target are ignored.
  assign redir_tgt       = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redir_lo = ^redirect_pc[1:0];

  // Issue only when the output register can take the result, so a response
  // always lands in an empty slot. Gated by rst_n so nothing escapes in reset.
  assign imem_req_valid = rst_n & (state == S_REQ) & space & !redirect_valid;
  assign imem_req_addr  = {pc_r[XLEN-1:2], 2'b00};
  assign accept         = imem_req_valid & imem_req_ready;

  // A response is only kept in S_WAIT and only if not redirected that cycle.
  assign rsp_load = (state == S_WAIT) & imem_rsp_valid & !redirect_valid;

  // Next PC: redirect target beats sequential advance; wraps at 2^XLEN.
  always_comb begin
    pc_d = pc_r;
    if (redirect_valid) pc_d = redir_tgt;
    else if (accept)    pc_d = pc_r + XLEN'(4);
  end

  dff_lr #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .en(redirect_valid | accept), .d(pc_d), .q(pc_r)
  );

  // PC of the request in flight, reported alongside its response.
  dff_lr #(.W(XLEN)) u_req_pc (
    .clk(clk), .rst_n(rst_n), .en(accept), .d(pc_r), .q(req_pc_r)
  );

  // Fetch FSM; a redirect while waiting converts the outstanding fetch into a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
    end else if (redirect_valid) begin
      case (state)
        S_WAIT, S_DROP: state <= imem_rsp_valid ? S_REQ : S_DROP;
        default:        state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ:   if (accept)         state <= S_WAIT;
        S_WAIT:  if (imem_rsp_valid) state <= S_REQ;
        S_DROP:  if (imem_rsp_valid) state <= S_REQ;
        default:                     state <= S_REQ;
      endcase
    end
  end

  ifu_out_stage #(.XW(XLEN), .IW(INSTR_W)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .load       (rsp_load),
    .load_pc    (req_pc_r),
    .load_instr (imem_rsp_data),
    .load_err   (imem_rsp_err),
    .out_ready  (if_ready),
    .out_valid  (if_valid),
    .out_pc     (if_pc),
    .out_instr  (if_instr),
    .out_err    (if_err),
    .space      (space)
  );

endmodule
